// File: rtl/param_fifo_pkg.sv
// Shared sizing helpers, default parameters and flag bundle for param_fifo.
package param_fifo_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_DEPTH  = 16;
   localparam int DEF_AFULL  = 14;
   localparam int DEF_AEMPTY = 2;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so the count can represent DEPTH itself.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } flags_t;

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer bus of param_fifo; master drives requests, slave is the FIFO.
interface param_fifo_if
   import param_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int CNT_W = cnt_width(DEPTH);

   logic             clr;
   logic             wr;
   logic [WIDTH-1:0] din;
   logic             rd;
   logic [WIDTH-1:0] dout;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             underflow;

   modport master (
      output clr, wr, din, rd,
      input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  clr, wr, din, rd,
      output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/param_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, contents never reset.
module param_fifo_mem
   import param_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int PTR_W = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO: 1-cycle registered read, or zero-latency head when PARAM_FIFO_FWFT_EN is defined.
// No backpressure: wr while full is dropped (overflow pulse), rd while empty is ignored (underflow pulse).
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int DEPTH         = DEF_DEPTH,
   parameter int AFULL_THRESH  = DEF_AFULL,
   parameter int AEMPTY_THRESH = DEF_AEMPTY
) (
   input  logic        clk,
   input  logic        rst,
   param_fifo_if.slave bus
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             unf;
   logic             wr_acc;
   logic             rd_acc;
   logic [WIDTH-1:0] rdata;
   flags_t           flags;

   assign flags.full         = (count == CNT_W'(DEPTH));
   assign flags.empty        = (count == '0);
   assign flags.almost_full  = (count >= CNT_W'(AFULL_THRESH));
   assign flags.almost_empty = (count <= CNT_W'(AEMPTY_THRESH));

   // Acceptance looks only at registered state, so a full FIFO never takes a write
   // even when a read frees a slot in the same cycle.
   assign wr_acc = bus.wr && !flags.full  && !bus.clr;
   assign rd_acc = bus.rd && !flags.empty && !bus.clr;

   param_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wptr),
      .wdata (bus.din),
      .raddr (rptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (bus.clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) rptr <= rptr + 1'b1;
         if (wr_acc && !rd_acc) begin
            count <= count + 1'b1;
         end else if (rd_acc && !wr_acc) begin
            count <= count - 1'b1;
         end
         ovf <= bus.wr && flags.full;
         unf <= bus.rd && flags.empty;
      end
   end

`ifdef PARAM_FIFO_FWFT_EN
   assign bus.dout = flags.empty ? '0 : rdata;
`else
   logic [WIDTH-1:0] dout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q <= '0;
      end else if (rd_acc) begin
         dout_q <= rdata;
      end
   end

   assign bus.dout = dout_q;
`endif

   assign bus.full         = flags.full;
   assign bus.empty        = flags.empty;
   assign bus.almost_full  = flags.almost_full;
   assign bus.almost_empty = flags.almost_empty;
   assign bus.count        = count;
   assign bus.overflow     = ovf;
   assign bus.underflow    = unf;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo against a queue-based reference model (registered or FWFT read).
module tb_param_fifo;

   localparam int W  = 8;
   localparam int D  = 16;
   localparam int AF = 14;
   localparam int AE = 2;
   localparam int VW = W + 5 + 6;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   param_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

   param_fifo #(
      .WIDTH         (W),
      .DEPTH         (D),
      .AFULL_THRESH  (AF),
      .AEMPTY_THRESH (AE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] q[$];
   logic [W-1:0] m_dout;
   bit           m_ovf;
   bit           m_unf;

   function automatic void model_reset();
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      int n;
      logic [W-1:0] d;
      n = q.size();
`ifdef PARAM_FIFO_FWFT_EN
      d = (n > 0) ? q[0] : '0;
`else
      d = m_dout;
`endif
      return {d, 5'(n), n == D, n == 0, n >= AF, n <= AE, m_ovf, m_unf};
   endfunction

   function automatic logic [VW-1:0] act_vec();
      return {bus.dout, bus.count, bus.full, bus.empty, bus.almost_full,
              bus.almost_empty, bus.overflow, bus.underflow};
   endfunction

   // Drives one cycle from a negedge, applies the model at the posedge, returns at the next negedge.
   task automatic cycle(input bit w, input bit r, input bit c, input logic [W-1:0] d);
      bit was_full;
      bit was_empty;
      bus.wr  = w;
      bus.rd  = r;
      bus.clr = c;
      bus.din = d;
      @(posedge clk);
      if (c) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         was_full  = (q.size() == D);
         was_empty = (q.size() == 0);
         if (r && !was_empty) m_dout = q.pop_front();
         if (w && !was_full)  q.push_back(d);
         m_ovf = w && was_full;
         m_unf = r && was_empty;
      end
      @(negedge clk);
      bus.wr  = 1'b0;
      bus.rd  = 1'b0;
      bus.clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      checks++;
      if (act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", act_vec(), exp_vec());
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, W'($urandom));
      cycle(0, 1, 0, '0);
      rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.dout !== 8'h00) begin
         errors++;
         $display("FAIL async_reset: count %0d empty %b dout %h want 0 1 00",
                  bus.count, bus.empty, bus.dout);
      end
      checks++;
      if (act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL async_reset_vec: got %h want %h", act_vec(), exp_vec());
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [W-1:0] v;
      for (int i = 0; i < D; i++) begin
         cycle(1, 0, 0, W'(i));
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL fill_%0d: got %h want %h", i, act_vec(), exp_vec());
         end
      end
      checks++;
      if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
         errors++;
         $display("FAIL full_at_16: full %b count %0d want 1 16", bus.full, bus.count);
      end
      cycle(1, 0, 0, 8'hEE);
      checks++;
      if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
         errors++;
         $display("FAIL overflow_17th: ovf %b count %0d want 1 16", bus.overflow, bus.count);
      end
      for (int i = 0; i < D; i++) begin
`ifdef PARAM_FIFO_FWFT_EN
         v = bus.dout;
         cycle(0, 1, 0, '0);
`else
         cycle(0, 1, 0, '0);
         v = bus.dout;
`endif
         checks++;
         if (v !== W'(i)) begin
            errors++;
            $display("FAIL drain_order_%0d: got %h want %h", i, v, W'(i));
         end
      end
      checks++;
      if (act_vec() !== exp_vec() || bus.empty !== 1'b1) begin
         errors++;
         $display("FAIL drained_empty: got %h want %h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_full_empty_rw();
      logic [W-1:0] v;
      for (int i = 0; i < D; i++) cycle(1, 0, 0, W'($urandom));
      cycle(1, 1, 0, 8'hAA);
      checks++;
      if (bus.overflow !== 1'b1 || bus.count !== 5'd15 || act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL full_wr_rd: got %h want %h (ovf 1 count 15)", act_vec(), exp_vec());
      end
      for (int i = 0; i < D - 1; i++) cycle(0, 1, 0, '0);
      checks++;
      if (act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL drain_after_full: got %h want %h", act_vec(), exp_vec());
      end
      cycle(1, 1, 0, 8'h55);
      checks++;
      if (bus.underflow !== 1'b1 || bus.count !== 5'd1 || act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL empty_wr_rd: got %h want %h (unf 1 count 1)", act_vec(), exp_vec());
      end
`ifdef PARAM_FIFO_FWFT_EN
      v = bus.dout;
      cycle(0, 1, 0, '0);
`else
      cycle(0, 1, 0, '0);
      v = bus.dout;
`endif
      checks++;
      if (v !== 8'h55) begin
         errors++;
         $display("FAIL read_55: got %h want 55", v);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] pat;
      pat = 8'h80;
      cycle(0, 0, 1, '0);
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 0, pat);
         pat++;
      end
      for (int i = 0; i < 40; i++) begin
         cycle(1, 1, 0, pat);
         pat++;
         checks++;
         if (bus.count !== 5'd8 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_%0d: got %h want %h", i, act_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 0, '0);
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_drain_%0d: got %h want %h", i, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_clear();
      logic [W-1:0] v;
      for (int i = 0; i < 6; i++) cycle(1, 0, 0, W'($urandom));
      cycle(1, 0, 1, 8'h99);
      checks++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 ||
          act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL clear: got %h want %h", act_vec(), exp_vec());
      end
      cycle(1, 0, 0, 8'h3C);
`ifdef PARAM_FIFO_FWFT_EN
      v = bus.dout;
      cycle(0, 1, 0, '0);
`else
      cycle(0, 1, 0, '0);
      v = bus.dout;
`endif
      checks++;
      if (v !== 8'h3C) begin
         errors++;
         $display("FAIL after_clear: got %h want 3c", v);
      end
   endtask

   task automatic test_single_word();
      cycle(1, 0, 0, 8'h77);
      checks++;
      if (act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL single_write: got %h want %h", act_vec(), exp_vec());
      end
`ifdef PARAM_FIFO_FWFT_EN
      checks++;
      if (bus.dout !== 8'h77) begin
         errors++;
         $display("FAIL fwft_head: got %h want 77", bus.dout);
      end
`endif
      cycle(0, 1, 0, '0);
      checks++;
      if (bus.empty !== 1'b1 || act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL single_read: got %h want %h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      bit w;
      bit r;
      bit c;
      for (int i = 0; i < 600; i++) begin
         if ((i / 100) % 2 == 0) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         c = ($urandom_range(0, 63) == 0);
         cycle(w, r, c, W'($urandom));
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_%0d: got %h want %h", i, act_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      bus.clr = 1'b0;
      bus.wr  = 1'b0;
      bus.rd  = 1'b0;
      bus.din = '0;
      test_reset();
      test_fill_drain();
      test_full_empty_rw();
      test_back_to_back();
      test_clear();
      test_single_word();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
